// File: rtl/encoder8x3_pending.sv
// encoder8x3_pending: latches 8 event request lines into a pending vector and
// offers them one at a time as a 3-bit binary code over a valid/ready handshake.
// Optional feature: define ENC_OVERFLOW_EN to add the sticky ovf output, which
// flags a request arriving on a line that is already pending.

module encoder8x3_pending #(
   parameter bit LOW_FIRST = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  req,
   input  logic        ready,
   output logic        valid,
   output logic [2:0]  code,
   output logic [7:0]  pend
`ifdef ENC_OVERFLOW_EN
   ,
   output logic        ovf
`endif
);

   localparam int unsigned NUM_REQ  = 8;
   localparam int unsigned CODE_W   = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic                valid_q, valid_d;
   logic [CODE_W-1:0]   code_q,  code_d;
   logic [NUM_REQ-1:0]  pend_q,  pend_d;
   logic [NUM_REQ-1:0]  clr_c;
   logic                accept_c;

   // Index of the highest-priority set bit; later loop iterations win.
   function automatic logic [CODE_W-1:0] pick_code(input logic [NUM_REQ-1:0] p);
      logic [CODE_W-1:0] c;
      c = '0;
      if (LOW_FIRST) begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (p[i]) c = CODE_W'(i);
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (p[i]) c = CODE_W'(i);
         end
      end
      return c;
   endfunction

   // Handshake completion and the one-hot clear of the accepted line.
   always_comb begin
      accept_c = valid_q && ready;
      clr_c    = '0;
      if (accept_c) clr_c = NUM_REQ'(1) << code_q;
   end

   // Pending vector: new requests are OR-ed in after the clear, so set wins.
   always_comb begin
      pend_d = (pend_q & ~clr_c) | req;
   end

   // Grant FSM: IDLE picks from the registered pending vector, OFFER holds
   // the code stable until the consumer accepts it.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      code_d  = code_q;
      unique case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (pend_q != '0) begin
               code_d  = pick_code(pend_q);
               valid_d = 1'b1;
               state_d = OFFER;
            end
         end
         OFFER: begin
            valid_d = 1'b1;
            if (ready) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, offer and pending registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         code_q  <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
      end
   end

`ifdef ENC_OVERFLOW_EN
   logic ovf_q, ovf_d;

   // Sticky overflow: a request hits a line that stays pending this cycle.
   always_comb begin
      ovf_d = ovf_q | (|(req & pend_q & ~clr_c));
   end

   // Overflow flag register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ovf_q <= 1'b0;
      else     ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

   assign valid = valid_q;
   assign code  = code_q;
   assign pend  = pend_q;

endmodule

// File: tb/tb_encoder8x3_pending.sv
// Bench for encoder8x3_pending: one instance per priority order, directed
// scenarios plus randomized traffic checked against a per-cycle reference model.

module tb_encoder8x3_pending;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       ready;

   logic       dv [2];
   logic [2:0] dc [2];
   logic [7:0] dp [2];
   logic       dovf [2];

   int checks;
   int errors;

   // reference model state, index = LOW_FIRST
   int  m_pend  [2];
   bit  m_valid [2];
   int  m_code  [2];
   bit  m_ovf   [2];

   encoder8x3_pending #(.LOW_FIRST(1'b0)) u_hi (
      .clk(clk), .rst(rst), .req(req), .ready(ready),
      .valid(dv[0]), .code(dc[0]), .pend(dp[0])
`ifdef ENC_OVERFLOW_EN
      , .ovf(dovf[0])
`endif
   );

   encoder8x3_pending #(.LOW_FIRST(1'b1)) u_lo (
      .clk(clk), .rst(rst), .req(req), .ready(ready),
      .valid(dv[1]), .code(dc[1]), .pend(dp[1])
`ifdef ENC_OVERFLOW_EN
      , .ovf(dovf[1])
`endif
   );

`ifndef ENC_OVERFLOW_EN
   assign dovf[0] = 1'b0;
   assign dovf[1] = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Lowest-index set bit if low_first, else highest-index set bit.
   function automatic int pick(input int p, input int low_first);
      int r;
      r = -1;
      for (int i = 0; i < 8; i++) begin
         if ((p >> i) & 1) begin
            if (low_first != 0) begin
               if (r < 0) r = i;
            end else begin
               r = i;
            end
         end
      end
      return r;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_valid[k] = 0; m_code[k] = 0; m_ovf[k] = 0;
      end
   endtask

   task automatic cmp_model(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.valid%0d", tag, k), 32'(dv[k]), 32'(m_valid[k]));
         chk($sformatf("%s.code%0d",  tag, k), 32'(dc[k]), 32'(m_code[k]));
         chk($sformatf("%s.pend%0d",  tag, k), 32'(dp[k]), 32'(m_pend[k]));
`ifdef ENC_OVERFLOW_EN
         chk($sformatf("%s.ovf%0d",   tag, k), 32'(dovf[k]), 32'(m_ovf[k]));
`endif
      end
   endtask

   // One clock: compute the model's next state from current inputs, clock,
   // then compare all outputs shortly after the edge.
   task automatic tick(input string tag);
      int  n_pend [2];
      bit  n_valid [2];
      int  n_code [2];
      bit  n_ovf [2];
      int  clr;
      for (int k = 0; k < 2; k++) begin
         clr = (m_valid[k] && ready) ? (1 << m_code[k]) : 0;
         n_pend[k]  = ((m_pend[k] & ~clr) | int'(req)) & 8'hFF;
         n_ovf[k]   = m_ovf[k] || ((int'(req) & m_pend[k] & ~clr) != 0);
         n_valid[k] = m_valid[k];
         n_code[k]  = m_code[k];
         if (!m_valid[k]) begin
            if (m_pend[k] != 0) begin
               n_valid[k] = 1;
               n_code[k]  = pick(m_pend[k], k);
            end
         end else if (ready) begin
            n_valid[k] = 0;
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = n_pend[k]; m_valid[k] = n_valid[k];
         m_code[k] = n_code[k]; m_ovf[k] = n_ovf[k];
      end
      #1;
      cmp_model(tag);
   endtask

   // Async reset pulse between edges, checked before the next edge.
   task automatic pulse_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("%s.rvalid%0d", tag, k), 32'(dv[k]), 32'd0);
         chk($sformatf("%s.rcode%0d",  tag, k), 32'(dc[k]), 32'd0);
         chk($sformatf("%s.rpend%0d",  tag, k), 32'(dp[k]), 32'd0);
`ifdef ENC_OVERFLOW_EN
         chk($sformatf("%s.rovf%0d",   tag, k), 32'(dovf[k]), 32'd0);
`endif
      end
      #1;
      rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      req    = '0;
      ready  = 1'b0;
      rst    = 1'b1;
      model_reset();
      #3;
      for (int k = 0; k < 2; k++) begin
         chk("reset.valid", 32'(dv[k]), 32'd0);
         chk("reset.code",  32'(dc[k]), 32'd0);
         chk("reset.pend",  32'(dp[k]), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      tick("idle");

      // single request
      req = 8'h04; ready = 1'b1;
      tick("single.e0");
      chk("single.pend", 32'(dp[0]), 32'h04);
      chk("single.nv",   32'(dv[0]), 32'd0);
      req = 8'h00;
      tick("single.e1");
      chk("single.valid", 32'(dv[0]), 32'd1);
      chk("single.code",  32'(dc[0]), 32'd2);
      tick("single.e2");
      chk("single.clr",  32'(dp[0]), 32'h00);
      chk("single.drop", 32'(dv[0]), 32'd0);

      // priority order both ways
      req = 8'h81; ready = 1'b1;
      tick("prio.e0");
      req = 8'h00;
      tick("prio.e1");
      chk("prio.hi1", 32'(dc[0]), 32'd7);
      chk("prio.lo1", 32'(dc[1]), 32'd0);
      tick("prio.e2");
      tick("prio.e3");
      chk("prio.hi2", 32'(dc[0]), 32'd0);
      chk("prio.lo2", 32'(dc[1]), 32'd7);
      chk("prio.v2",  32'(dv[1]), 32'd1);
      tick("prio.e4");
      chk("prio.empty", 32'(dp[0]), 32'h00);

      // hold under backpressure
      ready = 1'b0; req = 8'h08;
      tick("hold.e0");
      req = 8'h00;
      tick("hold.e1");
      req = 8'h80;
      tick("hold.e2");
      req = 8'h00;
      for (int i = 0; i < 3; i++) tick("hold.wait");
      chk("hold.code", 32'(dc[0]), 32'd3);
      chk("hold.v",    32'(dv[0]), 32'd1);
      ready = 1'b1;
      tick("hold.acc");
      tick("hold.next");
      chk("hold.next_hi", 32'(dc[0]), 32'd7);
      chk("hold.next_lo", 32'(dc[1]), 32'd7);
      tick("hold.drain");

      // set wins over clear
      ready = 1'b0; req = 8'h20;
      tick("swc.e0");
      req = 8'h00;
      tick("swc.e1");
      chk("swc.code", 32'(dc[0]), 32'd5);
      req = 8'h20; ready = 1'b1;
      tick("swc.acc");
      chk("swc.pend", 32'(dp[0]), 32'h20);
      req = 8'h00;
      tick("swc.regrant");
      chk("swc.recode", 32'(dc[0]), 32'd5);
      chk("swc.rev",    32'(dv[0]), 32'd1);
      tick("swc.drain");

      // reset in the middle of an offer
      ready = 1'b0; req = 8'h10;
      tick("rst.e0");
      req = 8'h00;
      tick("rst.e1");
      chk("rst.offer", 32'(dv[0]), 32'd1);
      pulse_reset("rst.mid");
      for (int i = 0; i < 3; i++) tick("rst.after");
      chk("rst.nogrant", 32'(dv[0]), 32'd0);

`ifdef ENC_OVERFLOW_EN
      // overflow: request on an already-pending line while stalled
      ready = 1'b0; req = 8'h02;
      tick("ovf.e0");
      req = 8'h00; tick("ovf.gap0");
      req = 8'h02; tick("ovf.p1");
      req = 8'h00; tick("ovf.gap1");
      req = 8'h02; tick("ovf.p2");
      req = 8'h00;
      chk("ovf.set", 32'(dovf[0]), 32'd1);
      ready = 1'b1;
      for (int i = 0; i < 4; i++) tick("ovf.hold");
      chk("ovf.sticky", 32'(dovf[0]), 32'd1);
      pulse_reset("ovf.rst");
`endif

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 99) == 0) pulse_reset("rnd.rst");
         req   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         ready = 1'($urandom_range(0, 2) != 0);
         tick("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/encoder8x3_pending.md
ENCODER8X3_PENDING -- requirements
Module: encoder8x3_pending

Interface
REQ-001 The block SHALL have parameter LOW_FIRST, default 0, meaning priority order (0: bit 7 highest; 1: bit 0 highest).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 8, event request lines, sampled each rising edge.
REQ-005 The block SHALL have port ready, input, 1, consumer accepts the offered code.
REQ-006 The block SHALL have port valid, output, 1, code holds an offered grant.
REQ-007 The block SHALL have port code, output, 3, binary index of the granted request.
REQ-008 The block SHALL have port pend, output, 8, registered pending-request vector.
REQ-009 The block SHALL have port ovf, output, 1, sticky overflow flag; present only when ENC_OVERFLOW_EN is defined.

Function
REQ-010 The block SHALL latch requests: each edge, pend <= (pend & ~clr) | req; clr is the one-hot of code when valid && ready, else 0.
REQ-011 The block SHALL let set win over clear: req[i] high in the same cycle that bit i is acknowledged leaves pend[i] = 1.
REQ-012 The block SHALL run a two-state FSM: IDLE (valid = 0) and OFFER (valid = 1).
REQ-013 The block SHALL, in IDLE with pend != 0, load code with the highest-priority set bit of pend per LOW_FIRST and move to OFFER.
REQ-014 The block SHALL, in IDLE with pend == 0, stay in IDLE with code unchanged.
REQ-015 The block SHALL, in OFFER with ready = 0, hold code and valid stable, even if a higher-priority req arrives.
REQ-016 The block SHALL, in OFFER with ready = 1, clear pend[code] per REQ-010/011 and return to IDLE.
REQ-017 The block SHALL give valid two edges after req is sampled into an empty idle block (edge N sets pend, edge N+1 loads code).
REQ-018 The block SHALL sustain at most one grant every two cycles (mandatory IDLE cycle between grants).
REQ-019 The block SHALL treat ready in IDLE as a no-op.
REQ-020 The block SHALL, when all 8 bits are pending, grant them in strict priority order, one per accepted handshake.

Reset
REQ-021 The block SHALL, while rst = 1, force pend = 8'h00, state = IDLE, valid = 0, code = 3'd0, ovf = 0, independent of clk.
REQ-022 The block SHALL, on reset asserted during OFFER, drop valid immediately and discard the offered and pending requests.
REQ-023 The block SHALL sample req first on the first rising edge after rst deasserts.

Configuration
REQ-024 The block SHALL, with ENC_OVERFLOW_EN defined, set ovf on any edge where req[i] = 1, pend[i] = 1 and bit i is not cleared that cycle.
REQ-025 The block SHALL, with ENC_OVERFLOW_EN defined, keep ovf set until reset.
REQ-026 The block SHALL, without ENC_OVERFLOW_EN, omit the ovf port and its logic, with all other behaviour identical.

Verification
REQ-027 The bench SHALL cover single request: LOW_FIRST = 0, req = 8'h04 for one cycle, ready = 1 -> valid high 2 edges later with code = 3'd2; one cycle later pend = 8'h00 and valid = 0.
REQ-028 The bench SHALL cover priority: req = 8'h81 pulse, ready = 1 -> grants code = 7 then code = 0; with LOW_FIRST = 1, code = 0 then code = 7.
REQ-029 The bench SHALL cover hold under backpressure: offering code = 3 with ready = 0, then req = 8'h80 -> code stays 3 until ready; next grant is 7.
REQ-030 The bench SHALL cover set-wins-clear: req[5] high in the same cycle as acceptance of code = 5 -> pend[5] stays 1 and code 5 is re-granted.
REQ-031 The bench SHALL cover reset mid-offer: rst pulsed between clk edges during OFFER -> valid = 0, pend = 0, code = 0 immediately; no grant follows.
REQ-032 The bench SHALL cover overflow (ENC_OVERFLOW_EN defined): req[1] pulsed twice while pend[1] = 1 and ready = 0 -> ovf = 1, held until rst.
